hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 The block SHALL have parameter NUM_FWD_SRC, default 2, meaning forwarding sources: 1 = MEM only, 2 = MEM and WB.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, range 1..3, meaning cycles flush_id/flush_ex stay high per taken branch.
REQ-003 The block SHALL have parameter LOAD_STALL_CYCLES, default 1, range 1..2, meaning cycles of stall per load-use hazard.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning width of the performance counters.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have ports id_instr, ex_instr, mem_instr, wb_instr, each input, 32 bits: instruction word in the ID, EX, MEM and WB stages.
REQ-008 The block SHALL have ports mem_reg_write and wb_reg_write, each input, 1 bit: register-write enable of the MEM and WB stages.
REQ-009 The block SHALL have port br_taken, input, 1 bit: branch/jump resolved taken in EX.
REQ-010 The block SHALL have ports fwd_a and fwd_b, each output, 2 bits: EX operand select, 0 = regfile, 1 = MEM result, 2 = WB result.
REQ-011 The block SHALL have ports stall_if and stall_id, each output, 1 bit: hold PC and the IF/ID register.
REQ-012 The block SHALL have ports flush_id and flush_ex, each output, 1 bit: bubble the IF/ID and ID/EX registers.
REQ-013 The block SHALL have ports stall_count and flush_count, each output, CNT_W bits: saturating event counters.

Function
REQ-014 A stage SHALL be a writer only when reg_write=1, rd=instr[11:7]!=0, and opcode instr[6:0] is neither STORE (0100011) nor BRANCH (1100011).
REQ-015 The MEM stage SHALL be a forwarding source only if it is a writer and its opcode is not LOAD (0000011).
REQ-016 fwd_a SHALL be 1 if ex_instr[19:15] equals the MEM rd and MEM is a source; otherwise 2 if it equals the WB rd, WB is a writer and NUM_FWD_SRC=2; otherwise 0.
REQ-017 fwd_b SHALL follow REQ-016 using ex_instr[24:20], evaluated independently of fwd_a, so both may be nonzero in the same cycle.
REQ-018 Forwarding outputs SHALL be purely combinational with zero latency.
REQ-019 A load-use hazard SHALL exist when ex_instr is LOAD with rd!=0 and id_instr[19:15] or id_instr[24:20] equals that rd.
REQ-020 The FSM SHALL have three states: RUN, STALL and FLUSH, with a 2-bit down-counter cnt.
REQ-021 In RUN, br_taken=1 SHALL assert flush_id and flush_ex in the same cycle; if FLUSH_CYCLES>1, the FSM SHALL go to FLUSH with cnt=FLUSH_CYCLES-2.
REQ-022 In RUN, with br_taken=0 and a load-use hazard, the block SHALL assert stall_if, stall_id and flush_ex in the same cycle; if LOAD_STALL_CYCLES>1, the FSM SHALL go to STALL with cnt=LOAD_STALL_CYCLES-2.
REQ-023 In FLUSH, the block SHALL assert flush_id and flush_ex; when cnt=0 it SHALL return to RUN, else decrement cnt.
REQ-024 In STALL, the block SHALL assert stall_if, stall_id and flush_ex; when cnt=0 it SHALL return to RUN, else decrement cnt.
REQ-025 br_taken SHALL take priority over a load-use hazard in the same cycle.
REQ-026 br_taken in STALL SHALL abort the stall and behave as REQ-021.
REQ-027 br_taken in FLUSH SHALL reload cnt to FLUSH_CYCLES-2 (or return to RUN if FLUSH_CYCLES=1) while flushing continues.
REQ-028 stall_count SHALL increment each cycle stall_id=1, and flush_count SHALL increment each cycle flush_id=1.
REQ-029 Both counters SHALL saturate at all-ones and SHALL never wrap.

Reset
REQ-030 rst=1 SHALL asynchronously force state RUN, cnt=0, stall_count=0 and flush_count=0.
REQ-031 While rst=1, stall_if, stall_id, flush_id and flush_ex SHALL be 0.
REQ-032 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the sequence; there SHALL be no residual assertion after release.

Structure
REQ-033 Package hazard_pkg SHALL hold the opcode constants (LOAD, STORE, BRANCH), the fwd_sel_e enum (NONE=0, MEM=1, WB=2) and the state enum.
REQ-034 Sub-module fwd_sel SHALL implement REQ-016 for one source-register address and SHALL be instantiated twice (operand A and operand B).

Verification
REQ-035 MEM=addi x5, WB=addi x5, EX=add x6,x5,x5 -> fwd_a=1, fwd_b=1 (MEM priority); with NUM_FWD_SRC=1 and MEM rd=x7 -> fwd_a=0.
REQ-036 EX=lw x5, ID=add x7,x5,x1, LOAD_STALL_CYCLES=2 -> stall_if, stall_id and flush_ex high for exactly 2 cycles; stall_count=2.
REQ-037 br_taken pulsed 1 cycle, FLUSH_CYCLES=3 -> flush_id and flush_ex high for exactly 3 cycles; flush_count=3.
REQ-038 br_taken in the second STALL cycle -> stall drops that cycle, flush begins; br_taken again mid-FLUSH -> flush window extends by FLUSH_CYCLES.
REQ-039 MEM=sw writing rd field x5 with reg_write=1, or any writer with rd=x0 -> fwd_a=fwd_b=0.
REQ-040 rst asserted mid-FLUSH -> all outputs 0 immediately (asynchronously); after release no flush occurs; CNT_W=4 with 20 stalls -> stall_count=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcode constants, forwarding-select and FSM state encodings
// for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_e;

    // Stores and branches carry an rd-shaped field that is not a destination.
    function automatic logic is_writer(input logic       reg_write,
                                       input logic [4:0] rd,
                                       input logic [6:0] opcode);
        return reg_write && (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Forwarding select for one EX source register; MEM has priority over WB.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int NUM_FWD_SRC = 2
) (
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_src,
    input  logic [4:0] wb_rd,
    input  logic       wb_wr,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = NONE;
        if (mem_src && (rs == mem_rd)) begin
            sel = MEM;
        end else if ((NUM_FWD_SRC == 2) && wb_wr && (rs == wb_rd)) begin
            sel = WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: operand forwarding, load-use stall and
// branch flush sequencing, plus saturating stall/flush event counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FWD_SRC       = 2,
    parameter int FLUSH_CYCLES      = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      ex_instr,
    input  logic [31:0]      mem_instr,
    input  logic [31:0]      wb_instr,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic             br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
    localparam logic [1:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    logic [4:0] mem_rd, wb_rd, ex_rd;
    logic       mem_wr, wb_wr, mem_src, load_use;
    fwd_sel_e   sel_a, sel_b;
    state_e     state;
    logic [1:0] cnt;
    logic       flush_act, stall_act;
    logic       unused_bits;

    assign mem_rd  = mem_instr[11:7];
    assign wb_rd   = wb_instr[11:7];
    assign ex_rd   = ex_instr[11:7];
    assign mem_wr  = is_writer(mem_reg_write, mem_rd, mem_instr[6:0]);
    assign wb_wr   = is_writer(wb_reg_write, wb_rd, wb_instr[6:0]);
    // A load in MEM has no data yet, so it can only be handled by the stall.
    assign mem_src = mem_wr && (mem_instr[6:0] != OP_LOAD);

    assign load_use = (ex_instr[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                      ((id_instr[19:15] == ex_rd) || (id_instr[24:20] == ex_rd));

    assign unused_bits = ^{id_instr[31:25], id_instr[14:0], ex_instr[31:25], ex_instr[14:12],
                           mem_instr[31:12], wb_instr[31:12]};

    fwd_sel #(.NUM_FWD_SRC(NUM_FWD_SRC)) u_fwd_a (
        .rs      (ex_instr[19:15]),
        .mem_rd  (mem_rd),
        .mem_src (mem_src),
        .wb_rd   (wb_rd),
        .wb_wr   (wb_wr),
        .sel     (sel_a)
    );

    fwd_sel #(.NUM_FWD_SRC(NUM_FWD_SRC)) u_fwd_b (
        .rs      (ex_instr[24:20]),
        .mem_rd  (mem_rd),
        .mem_src (mem_src),
        .wb_rd   (wb_rd),
        .wb_wr   (wb_wr),
        .sel     (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    // First cycle of a stall/flush is signalled combinationally from RUN;
    // the FSM only covers the remaining cycles.
    always_comb begin
        flush_act = br_taken || (state == FLUSH);
        stall_act = !br_taken && ((state == STALL) || ((state == RUN) && load_use));
    end

    assign stall_if = !rst && stall_act;
    assign stall_id = !rst && stall_act;
    assign flush_id = !rst && flush_act;
    assign flush_ex = !rst && (flush_act || stall_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (br_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state <= FLUSH;
                cnt   <= FLUSH_RELOAD;
            end else begin
                state <= RUN;
                cnt   <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                        state <= STALL;
                        cnt   <= STALL_RELOAD;
                    end
                end
                STALL, FLUSH: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - 2'd1;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_id && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (flush_id && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two parameterisations share the same stimulus,
// checked by directed scenarios and a remaining-cycles reference model.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int N = 2;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr, ex_instr, mem_instr, wb_instr;
    logic        mem_reg_write, wb_reg_write, br_taken;

    logic [1:0]  fa [N];
    logic [1:0]  fb [N];
    logic        sif [N];
    logic        sid [N];
    logic        fid [N];
    logic        fex [N];
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    // Per-instance parameters: NUM_FWD_SRC, FLUSH_CYCLES, LOAD_STALL_CYCLES, counter max
    int     p_nfs [N] = '{2, 1};
    int     p_fc  [N] = '{3, 1};
    int     p_lsc [N] = '{2, 1};
    longint p_max [N] = '{64'hFFFF_FFFF, 64'd15};

    int     flush_rem [N];
    int     stall_rem [N];
    longint m_sc [N];
    longint m_fc [N];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .NUM_FWD_SRC(2), .FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(2), .CNT_W(32)
    ) dut0 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
        .mem_instr(mem_instr), .wb_instr(wb_instr), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .br_taken(br_taken), .fwd_a(fa[0]), .fwd_b(fb[0]),
        .stall_if(sif[0]), .stall_id(sid[0]), .flush_id(fid[0]), .flush_ex(fex[0]),
        .stall_count(sc0), .flush_count(fc0)
    );

    hazard_ctrl_unit #(
        .NUM_FWD_SRC(1), .FLUSH_CYCLES(1), .LOAD_STALL_CYCLES(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
        .mem_instr(mem_instr), .wb_instr(wb_instr), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .br_taken(br_taken), .fwd_a(fa[1]), .fwd_b(fb[1]),
        .stall_if(sif[1]), .stall_id(sid[1]), .flush_id(fid[1]), .flush_ex(fex[1]),
        .stall_count(sc1), .flush_count(fc1)
    );

    function automatic logic [31:0] alu(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OP_ALU};
    endfunction

    function automatic logic [31:0] itype(input logic [6:0] op, input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    function automatic logic [31:0] store(input int rs1, input int rs2, input int imm_lo);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'(imm_lo), OP_STORE};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [5] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_ALU, OP_IMM};
        return {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'd0,
                5'($urandom_range(0, 7)), ops[$urandom_range(0, 4)]};
    endfunction

    function automatic logic [3:0] ctl(input int i);
        return {sif[i], sid[i], fid[i], fex[i]};
    endfunction

    function automatic logic [7:0] got_vec(input int i);
        return {fa[i], fb[i], sif[i], sid[i], fid[i], fex[i]};
    endfunction

    function automatic longint got_sc(input int i);
        return (i == 0) ? longint'(sc0) : longint'(sc1);
    endfunction

    function automatic longint got_fc(input int i);
        return (i == 0) ? longint'(fc0) : longint'(fc1);
    endfunction

    // ---------------- reference model ----------------
    function automatic bit writes(input logic [31:0] ins, input logic rw);
        return rw && ins[11:7] != 0 && ins[6:0] != OP_STORE && ins[6:0] != OP_BRANCH;
    endfunction

    function automatic int exp_fwd(input int i, input logic [4:0] rs);
        if (writes(mem_instr, mem_reg_write) && mem_instr[6:0] != OP_LOAD && rs == mem_instr[11:7])
            return 1;
        if (p_nfs[i] == 2 && writes(wb_instr, wb_reg_write) && rs == wb_instr[11:7])
            return 2;
        return 0;
    endfunction

    function automatic bit ref_load_use();
        logic [4:0] rd = ex_instr[11:7];
        return ex_instr[6:0] == OP_LOAD && rd != 0 &&
               (id_instr[19:15] == rd || id_instr[24:20] == rd);
    endfunction

    function automatic bit exp_flush(input int i);
        return br_taken || flush_rem[i] > 0;
    endfunction

    function automatic bit exp_stall(input int i);
        return !br_taken && (stall_rem[i] > 0 || (flush_rem[i] == 0 && ref_load_use()));
    endfunction

    function automatic logic [7:0] model_vec(input int i);
        bit s = exp_stall(i);
        bit f = exp_flush(i);
        return {2'(exp_fwd(i, ex_instr[19:15])), 2'(exp_fwd(i, ex_instr[24:20])), s, s, f, f | s};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            flush_rem[i] = 0; stall_rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    // Advance one clock: capture this cycle's expected events, step the model.
    task automatic tick();
        bit es [N];
        bit ef [N];
        bit lu;
        bit br;
        lu = ref_load_use();
        br = br_taken;
        for (int i = 0; i < N; i++) begin
            es[i] = exp_stall(i);
            ef[i] = exp_flush(i);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (es[i] && m_sc[i] < p_max[i]) m_sc[i]++;
            if (ef[i] && m_fc[i] < p_max[i]) m_fc[i]++;
            if (br) begin
                flush_rem[i] = p_fc[i] - 1;
                stall_rem[i] = 0;
            end else if (flush_rem[i] > 0) flush_rem[i]--;
            else if (stall_rem[i] > 0)     stall_rem[i]--;
            else if (lu)                   stall_rem[i] = p_lsc[i] - 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_instr = itype(OP_IMM, 0, 0); ex_instr = itype(OP_IMM, 0, 0);
        mem_instr = itype(OP_IMM, 0, 0); wb_instr = itype(OP_IMM, 0, 0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; br_taken = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        br_taken = 1'b1;
        ex_instr = itype(OP_LOAD, 5, 2);
        id_instr = alu(7, 5, 1);
        #2;
        for (int i = 0; i < N; i++) begin
            total++;
            if (ctl(i) !== 4'b0000 || got_sc(i) != 0 || got_fc(i) != 0)
                $display("FAIL reset_state dut%0d: ctl=%b sc=%0d fc=%0d, required ctl=0000 sc=0 fc=0",
                         i, ctl(i), got_sc(i), got_fc(i));
            else passed++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            total++;
            if (ctl(i) !== 4'b0000 || got_sc(i) != 0)
                $display("FAIL reset_hold dut%0d: ctl=%b sc=%0d, required 0000/0", i, ctl(i), got_sc(i));
            else passed++;
        end
        rst = 1'b0;
        model_reset();
        idle_inputs();
    endtask

    task automatic test_forwarding();
        // columns: mem, mem_rw, wb, wb_rw, ex, then {fa,fb} for dut0 and dut1
        logic [31:0] t_mem [6];
        logic [31:0] t_wb  [6];
        logic [31:0] t_ex  [6];
        logic        t_mrw [6] = '{1, 1, 1, 1, 0, 1};
        logic        t_wrw [6] = '{1, 1, 1, 1, 0, 1};
        logic [3:0]  t_e0  [6] = '{4'b0101, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1001};
        logic [3:0]  t_e1  [6] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        t_mem = '{itype(OP_IMM, 5, 1), itype(OP_IMM, 7, 1), store(1, 2, 5),
                  itype(OP_LOAD, 5, 1), itype(OP_IMM, 5, 1), itype(OP_IMM, 9, 1)};
        t_wb  = '{itype(OP_IMM, 5, 2), itype(OP_IMM, 5, 2), itype(OP_IMM, 0, 5),
                  itype(OP_IMM, 5, 2), itype(OP_IMM, 5, 2), itype(OP_IMM, 5, 2)};
        t_ex  = '{alu(6, 5, 5), alu(6, 5, 5), alu(6, 5, 5), alu(6, 5, 5), alu(6, 5, 5), alu(6, 5, 9)};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            mem_instr = t_mem[k]; mem_reg_write = t_mrw[k];
            wb_instr  = t_wb[k];  wb_reg_write  = t_wrw[k];
            ex_instr  = t_ex[k];
            #2;
            total++;
            if ({fa[0], fb[0]} !== t_e0[k])
                $display("FAIL fwd_case%0d dut0: fwd_a/b=%b, required %b", k, {fa[0], fb[0]}, t_e0[k]);
            else passed++;
            total++;
            if ({fa[1], fb[1]} !== t_e1[k])
                $display("FAIL fwd_case%0d dut1: fwd_a/b=%b, required %b", k, {fa[1], fb[1]}, t_e1[k]);
            else passed++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        logic [3:0] e0 [3] = '{4'b1101, 4'b1101, 4'b0000};
        logic [3:0] e1 [3] = '{4'b1101, 4'b0000, 4'b0000};
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            ex_instr = (k == 0) ? itype(OP_LOAD, 5, 2) : (k == 1) ? itype(OP_IMM, 0, 0) : alu(7, 5, 1);
            id_instr = (k < 2) ? alu(7, 5, 1) : itype(OP_IMM, 0, 0);
            #2;
            total++;
            if (ctl(0) !== e0[k] || ctl(1) !== e1[k])
                $display("FAIL load_use_cyc%0d: dut0=%b dut1=%b, required %b %b", k, ctl(0), ctl(1), e0[k], e1[k]);
            else passed++;
            tick();
        end
        total++;
        if (sc0 !== 32'd2 || fc0 !== 32'd0 || sc1 !== 4'd1)
            $display("FAIL load_use_count: sc0=%0d fc0=%0d sc1=%0d, required 2 0 1", sc0, fc0, sc1);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_branch();
        logic [3:0] e0 [4] = '{4'b0011, 4'b0011, 4'b0011, 4'b0000};
        logic [3:0] e1 [4] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            br_taken = (k == 0);
            ex_instr = (k == 0) ? itype(OP_LOAD, 5, 2) : itype(OP_IMM, 0, 0);
            id_instr = alu(7, 5, 1);
            #2;
            total++;
            if (ctl(0) !== e0[k] || ctl(1) !== e1[k])
                $display("FAIL branch_cyc%0d: dut0=%b dut1=%b, required %b %b", k, ctl(0), ctl(1), e0[k], e1[k]);
            else passed++;
            tick();
        end
        total++;
        if (fc0 !== 32'd3 || fc1 !== 4'd1 || sc0 !== 32'd0)
            $display("FAIL branch_count: fc0=%0d fc1=%0d sc0=%0d, required 3 1 0", fc0, fc1, sc0);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_branch_in_stall();
        logic       br [7] = '{0, 1, 0, 1, 0, 0, 0};
        logic [3:0] e0 [7] = '{4'b1101, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
        logic [3:0] e1 [7] = '{4'b1101, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        apply_reset();
        id_instr = alu(7, 5, 1);
        for (int k = 0; k < 7; k++) begin
            br_taken = br[k];
            ex_instr = (k == 0) ? itype(OP_LOAD, 5, 2) : itype(OP_IMM, 0, 0);
            #2;
            total++;
            if (ctl(0) !== e0[k] || ctl(1) !== e1[k])
                $display("FAIL br_stall_cyc%0d: dut0=%b dut1=%b, required %b %b", k, ctl(0), ctl(1), e0[k], e1[k]);
            else passed++;
            tick();
        end
        total++;
        if (sc0 !== 32'd1 || fc0 !== 32'd5 || sc1 !== 4'd1 || fc1 !== 4'd2)
            $display("FAIL br_stall_count: sc0=%0d fc0=%0d sc1=%0d fc1=%0d, required 1 5 1 2",
                     sc0, fc0, sc1, fc1);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        #2;
        total++;
        if (ctl(0) !== 4'b0011)
            $display("FAIL mid_flush_pre: dut0=%b, required 0011", ctl(0));
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (ctl(0) !== 4'b0000 || fc0 !== 32'd0 || fc1 !== 4'd0)
            $display("FAIL mid_flush_async: dut0=%b fc0=%0d fc1=%0d, required 0000 0 0", ctl(0), fc0, fc1);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            #2;
            total++;
            if (ctl(0) !== 4'b0000 || ctl(1) !== 4'b0000)
                $display("FAIL after_reset_cyc%0d: dut0=%b dut1=%b, required 0000 0000", k, ctl(0), ctl(1));
            else passed++;
            tick();
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        ex_instr = itype(OP_LOAD, 5, 2);
        id_instr = alu(7, 1, 5);
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (sc1 !== 4'd15 || sc0 !== 32'd20)
            $display("FAIL stall_saturate: sc1=%0d sc0=%0d, required 15 20", sc1, sc0);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            id_instr = rand_instr(); ex_instr = rand_instr();
            mem_instr = rand_instr(); wb_instr = rand_instr();
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            br_taken      = ($urandom_range(0, 5) == 0);
            #2;
            for (int i = 0; i < N; i++) begin
                total++;
                if (got_vec(i) !== model_vec(i))
                    $display("FAIL rand_out dut%0d cyc%0d: {fa,fb,sif,sid,fid,fex}=%b, required %b",
                             i, k, got_vec(i), model_vec(i));
                else passed++;
            end
            tick();
            for (int i = 0; i < N; i++) begin
                total++;
                if (got_sc(i) != m_sc[i] || got_fc(i) != m_fc[i])
                    $display("FAIL rand_cnt dut%0d cyc%0d: sc=%0d fc=%0d, required %0d %0d",
                             i, k, got_sc(i), got_fc(i), m_sc[i], m_fc[i]);
                else passed++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_branch_in_stall();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
